instr_fetch_responder: RTL and testbench

- Instruction-side responder at the far end of the PC-driven fetch interface.
- Accepts a fetch request carrying a 64-bit byte address, which in the datapath is the current PC value.
- Reads one 32-bit instruction word from an internal word-addressed instruction store and returns it after a fixed latency through a valid/ready response handshake.
- Flags misaligned and out-of-range fetches. A separate write port loads the program image.

---
 rtl/instr_fetch_responder.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Fetch responder: returns one 32-bit word from a word-addressed store, LATENCY cycles after accept.
// One request in flight; the response is held stable until resp_ready, and req_ready returns the cycle after.
module instr_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [63:0]                    req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_instr,
  output logic [63:0]                    resp_addr,
  output logic                           resp_fault,
  output logic [1:0]                     resp_fault_code,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_data,
  output logic                           busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic [31:0]   instr_q, instr_d;
  logic [63:0]   addr_q, addr_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [63:0]   offset;
  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    acc_code;
  logic [31:0]   rd_word;
  logic          accept;

  // BASE_ADDR is word aligned, so offset[1:0] equals req_addr[1:0].
  always_comb begin
    offset       = req_addr - BASE_ADDR;
    misaligned   = (offset[1:0] != 2'b00);
    out_of_range = (req_addr < BASE_ADDR) || (offset[63:2] >= 62'(DEPTH_WORDS));
    if (misaligned) begin
      acc_code = 2'b01;
    end else if (out_of_range) begin
      acc_code = 2'b10;
    end else begin
      acc_code = 2'b00;
    end
    rd_word = mem[offset[AW+1:2]];
    accept  = req_valid && req_ready_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    fault_d      = fault_q;
    code_d       = code_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d      = req_addr;
          code_d      = acc_code;
          fault_d     = (acc_code != 2'b00);
          instr_d     = (acc_code != 2'b00) ? NOP : rd_word;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (LATENCY == 1) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      instr_q      <= 32'h0;
      addr_q       <= 64'h0;
      fault_q      <= 1'b0;
      code_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
    end
  end

  // Store is deliberately unreset; writes are only gated off while reset is held.
  always_ff @(posedge clock) begin
    if (prog_we && !reset) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign busy            = busy_q;
  assign resp_instr      = instr_q;
  assign resp_addr       = addr_q;
  assign resp_fault      = fault_q;
  assign resp_fault_code = code_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: directed steps plus random fetches against a behavioural model.
module tb_instr_fetch_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [63:0] BASE  = 64'h0;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_instr;
  logic [63:0] resp_addr;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'h0;
  logic [31:0] prog_data = 32'h0;
  logic        busy;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [63:0] req_addr1 = 64'h0;
  logic        resp_valid1;
  logic        resp_ready1 = 1'b1;
  logic [31:0] resp_instr1;
  logic [63:0] resp_addr1;
  logic        resp_fault1;
  logic [1:0]  resp_fault_code1;
  logic        busy1;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clock = ~clock;

  instr_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_fault(resp_fault), .resp_fault_code(resp_fault_code),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  instr_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_instr(resp_instr1),
    .resp_addr(resp_addr1), .resp_fault(resp_fault1), .resp_fault_code(resp_fault_code1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: fault code and returned word straight from the address rules.
  task automatic predict(input logic [63:0] a, output logic [1:0] code, output logic [31:0] instr);
    longint unsigned off;
    off = a - BASE;
    if (a % 4 != 0) code = 2'b01;
    else if (a < BASE || off / 4 >= DEPTH) code = 2'b10;
    else code = 2'b00;
    instr = (code != 2'b00) ? NOP : model_mem[off / 4];
  endtask

  task automatic prog_write(input int idx, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = 8'(idx); prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
    model_mem[idx] = d;
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic fetch(input logic [63:0] a, input int hold, input bit wr_during,
                       input bit col, input logic [31:0] col_data);
    logic [1:0]  ec;
    logic [31:0] ei;
    int          cyc;
    int          widx;
    logic [31:0] wdat;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(posedge clock); #1; cyc++; end
    check("req_ready_before_accept", 64'(req_ready), 64'd1);
    predict(a, ec, ei);
    req_valid = 1'b1; req_addr = a;
    if (col) begin
      prog_we = 1'b1; prog_addr = 8'((a - BASE) / 4); prog_data = col_data;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (col) begin
      prog_we = 1'b0;
      model_mem[(a - BASE) / 4] = col_data;
    end
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      check("req_ready_low_wait", 64'(req_ready), 64'd0);
      check("busy_wait", 64'(busy), 64'd1);
      @(posedge clock); #1; cyc++;
    end
    check("latency", 64'(cyc), 64'd2);
    check("resp_instr", 64'(resp_instr), 64'(ei));
    check("resp_addr", resp_addr, a);
    check("resp_fault", 64'(resp_fault), 64'(ec != 2'b00));
    check("resp_fault_code", 64'(resp_fault_code), 64'(ec));
    check("req_ready_low_resp", 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      if (wr_during && i == 0) begin
        widx = (ec == 2'b00) ? int'((a - BASE) / 4) : int'($urandom_range(0, DEPTH - 1));
        wdat = $urandom;
        prog_we = 1'b1; prog_addr = 8'(widx); prog_data = wdat;
      end
      @(posedge clock); #1;
      if (prog_we) begin
        prog_we = 1'b0;
        model_mem[widx] = wdat;
      end
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_instr", 64'(resp_instr), 64'(ei));
      check("hold_addr", resp_addr, a);
      check("hold_code", 64'(resp_fault_code), 64'(ec));
      check("hold_fault", 64'(resp_fault), 64'(ec != 2'b00));
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("after_hs_valid", 64'(resp_valid), 64'd0);
    check("after_hs_ready", 64'(req_ready), 64'd1);
    check("after_hs_busy", 64'(busy), 64'd0);
    check("after_hs_instr", 64'(resp_instr), 64'(ei));
    check("after_hs_addr", resp_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int          kind;
    logic [31:0] old3;

    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_fault", 64'(resp_fault), 64'd0);
    check("rst_code", 64'(resp_fault_code), 64'd0);
    check("rst_instr", 64'(resp_instr), 64'd0);
    check("rst_addr", resp_addr, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready_l1", 64'(req_ready1), 64'd1);
    check("rst_resp_valid_l1", 64'(resp_valid1), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < int'(DEPTH); i++) prog_write(i, $urandom);
    prog_write(0, 32'h00500093);
    prog_write(1, 32'h00A00113);
    prog_write(2, 32'h00000033);

    fetch(64'h0, 0, 1'b0, 1'b0, 32'h0);
    fetch(64'h4, 0, 1'b0, 1'b0, 32'h0);
    fetch(64'h4, 5, 1'b0, 1'b0, 32'h0);

    fetch(64'h6,   0, 1'b0, 1'b0, 32'h0);
    fetch(64'h400, 1, 1'b0, 1'b0, 32'h0);
    fetch(64'h3FC, 0, 1'b0, 1'b0, 32'h0);
    fetch(64'h402, 0, 1'b0, 1'b0, 32'h0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 1'b0, 1'b0, 32'h0);

    fetch(64'h8, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    fetch(64'h8, 0, 1'b0, 1'b0, 32'h0);
    check("collision_model", 64'(model_mem[2]), 64'h00000000DEADBEEF);

    fetch(64'h10, 2, 1'b1, 1'b0, 32'h0);
    fetch(64'h10, 0, 1'b0, 1'b0, 32'h0);

    // Reset while the request is in WAIT; also a store write attempted under reset.
    old3 = model_mem[3];
    req_valid = 1'b1; req_addr = 64'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    prog_we = 1'b1; prog_addr = 8'd3; prog_data = ~old3;
    @(posedge clock); #1;
    prog_we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("postrst_no_resp", 64'(resp_valid), 64'd0);
      check("postrst_ready", 64'(req_ready), 64'd1);
    end
    fetch(64'hC, 0, 1'b0, 1'b0, 32'h0);
    fetch(64'h0, 0, 1'b0, 1'b0, 32'h0);

    req_valid1 = 1'b1; req_addr1 = 64'h4;
    @(posedge clock); #1;
    req_valid1 = 1'b0;
    check("lat1_valid", 64'(resp_valid1), 64'd1);
    check("lat1_instr", 64'(resp_instr1), 64'(model_mem[1]));
    check("lat1_addr", resp_addr1, 64'h4);
    check("lat1_ready_low", 64'(req_ready1), 64'd0);
    @(posedge clock); #1;
    check("lat1_done", 64'(resp_valid1), 64'd0);
    check("lat1_ready_back", 64'(req_ready1), 64'd1);

    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = 64'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind < 8) a = 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(1, 3));
      else if (kind < 9) a = 64'h400 + 64'($urandom_range(0, 4000)) * 4;
      else               a = {$urandom, $urandom} | 64'h1_0000_0000;
      if ($urandom_range(0, 2) == 0) prog_write(int'($urandom_range(0, DEPTH - 1)), $urandom);
      fetch(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
